// File: rtl/fir_pkg.sv
// fir_pkg: shared helpers for the symmetric streaming FIR family.
// Holds clog2, the accumulator width rule and the 9-tap default bank.
package fir_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Full-precision accumulator width for u folded products.
    function automatic int acc_w(input int dw, input int cw, input int u);
        return dw + cw + 1 + clog2(u);
    endfunction

    localparam int DEF_U = 5;
    localparam int DEF_COEF [DEF_U] = '{2, -5, 10, -20, 112};

    // Reset value of unique coefficient i; other lengths reset to a
    // centre-tap passthrough.
    function automatic int default_coef(input int i, input int u);
        if (u == DEF_U) return DEF_COEF[i];
        return (i == u - 1) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_add_tree.sv
// fir_add_tree: registered pairwise adder tree with a valid passthrough.
// Ports: clk, reset, in_valid, in_data[N] -> out_valid, out_data (LEVELS later).
module fir_add_tree
    import fir_pkg::*;
#(
    parameter int N      = 5,
    parameter int W      = 36,
    parameter int LEVELS = clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data [N],
    output logic                out_valid,
    output logic signed [W-1:0] out_data
);

    function automatic int cnt(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    // First node of level l in the flattened node list; level 0 = inputs.
    function automatic int off(input int l);
        int s;
        s = 0;
        for (int j = 0; j < l; j++) s += cnt(j);
        return s;
    endfunction

    localparam int ALL = off(LEVELS + 1);
    localparam int REG = ALL - N;

    logic signed [W-1:0] node  [ALL];
    logic signed [W-1:0] sum_d [REG];
    logic signed [W-1:0] sum_q [REG];
    logic [LEVELS-1:0]   vld_d;
    logic [LEVELS-1:0]   vld_q;

    always_comb begin
        for (int i = 0; i < N; i++) node[i] = in_data[i];
        for (int i = 0; i < REG; i++) node[N + i] = sum_q[i];
    end

    // An unpaired last node is simply re-registered.
    always_comb begin
        sum_d = sum_q;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int k = 0; k < cnt(l); k++) begin
                if (2 * k + 1 < cnt(l - 1))
                    sum_d[off(l) - N + k] = node[off(l - 1) + 2 * k]
                                          + node[off(l - 1) + 2 * k + 1];
                else
                    sum_d[off(l) - N + k] = node[off(l - 1) + 2 * k];
            end
        end
    end

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG; i++) sum_q[i] <= '0;
            vld_q <= '0;
        end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
        end
    end

    assign out_data  = node[ALL - 1];
    assign out_valid = vld_q[LEVELS - 1];

endmodule

// File: rtl/fir_sym_stream.sv
// fir_sym_stream: folded symmetric FIR, valid-qualified, round + saturate.
// Ports: clk, reset, in_valid/data_in, coef_we/addr/data/swap, out_valid/data_out.
module fir_sym_stream
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 9,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic signed [DATA_W-1:0]         data_in,
    input  logic                             coef_we,
    input  logic [clog2((TAPS+1)/2)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]         coef_data,
    input  logic                             coef_swap,
    output logic                             out_valid,
    output logic signed [OUT_W-1:0]          data_out
);

    localparam int U     = (TAPS + 1) / 2;
    localparam int TREE  = clog2(U);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, U);
    localparam int PW    = DATA_W + 1;
    localparam int MW    = PW + COEF_W;
    localparam int RW    = ACC_W + 1;
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [DATA_W-1:0] dl_d  [TAPS];
    logic signed [DATA_W-1:0] dl_q  [TAPS];
    logic signed [PW-1:0]     pre_d [U];
    logic signed [PW-1:0]     pre_q [U];
    logic signed [COEF_W-1:0] shd_d [U];
    logic signed [COEF_W-1:0] shd_q [U];
    logic signed [COEF_W-1:0] act_d [U];
    logic signed [COEF_W-1:0] act_q [U];
    logic signed [MW-1:0]     mul_d [U];
    logic signed [MW-1:0]     mul_q [U];
    logic signed [ACC_W-1:0]  tree_in [U];
    logic signed [ACC_W-1:0]  tree_sum;
    logic                     tree_vld;
    logic signed [RW-1:0]     rnd_d, rnd_q;
    logic signed [OUT_W-1:0]  sat;
    logic signed [OUT_W-1:0]  out_d, out_q;
    logic dl_vld_d,  dl_vld_q;
    logic pre_vld_d, pre_vld_q;
    logic mul_vld_d, mul_vld_q;
    logic rnd_vld_d, rnd_vld_q;
    logic out_vld_d, out_vld_q;

    // Delay line and folding pre-adders.
    always_comb begin
        dl_d = dl_q;
        if (in_valid) begin
            dl_d[0] = data_in;
            for (int i = 1; i < TAPS; i++) dl_d[i] = dl_q[i - 1];
        end
        dl_vld_d = in_valid;
        for (int i = 0; i < U - 1; i++)
            pre_d[i] = PW'(dl_q[i]) + PW'(dl_q[TAPS - 1 - i]);
        pre_d[U - 1] = PW'(dl_q[U - 1]);
        pre_vld_d = dl_vld_q;
    end

    // A same-cycle write is visible to the swap through shd_d.
    always_comb begin
        shd_d = shd_q;
        if (coef_we && (int'(coef_addr) < U))
            shd_d[coef_addr] = coef_data;
        act_d = act_q;
        if (coef_swap) act_d = shd_d;
    end

    always_comb begin
        for (int i = 0; i < U; i++) begin
            mul_d[i]   = MW'(pre_q[i]) * MW'(act_q[i]);
            tree_in[i] = ACC_W'(mul_q[i]);
        end
        mul_vld_d = pre_vld_q;
    end

    fir_add_tree #(
        .N      (U),
        .W      (ACC_W),
        .LEVELS (TREE)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_vld_q),
        .in_data   (tree_in),
        .out_valid (tree_vld),
        .out_data  (tree_sum)
    );

    // One extra bit so the rounding constant cannot wrap.
    always_comb begin
        rnd_d     = (RW'(tree_sum) + RND) >>> SHIFT;
        rnd_vld_d = tree_vld;
    end

    generate
        if (OUT_W >= RW) begin : g_wide
            always_comb sat = OUT_W'(rnd_q);
        end else begin : g_sat
            logic [RW-OUT_W:0] top;
            always_comb begin
                top = rnd_q[RW-1:OUT_W-1];
                if ((&top) || !(|top))
                    sat = rnd_q[OUT_W-1:0];
                else
                    sat = {rnd_q[RW-1], {(OUT_W-1){~rnd_q[RW-1]}}};
            end
        end
    endgenerate

    always_comb begin
        out_d     = rnd_vld_q ? sat : out_q;
        out_vld_d = rnd_vld_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) dl_q[i] <= '0;
            for (int i = 0; i < U; i++) begin
                pre_q[i] <= '0;
                mul_q[i] <= '0;
                shd_q[i] <= COEF_W'(default_coef(i, U));
                act_q[i] <= COEF_W'(default_coef(i, U));
            end
            rnd_q     <= '0;
            out_q     <= '0;
            dl_vld_q  <= 1'b0;
            pre_vld_q <= 1'b0;
            mul_vld_q <= 1'b0;
            rnd_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            dl_q      <= dl_d;
            pre_q     <= pre_d;
            mul_q     <= mul_d;
            shd_q     <= shd_d;
            act_q     <= act_d;
            rnd_q     <= rnd_d;
            out_q     <= out_d;
            dl_vld_q  <= dl_vld_d;
            pre_vld_q <= pre_vld_d;
            mul_vld_q <= mul_vld_d;
            rnd_vld_q <= rnd_vld_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign data_out  = out_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_fir_sym_stream.sv
// tb_fir_sym_stream: scoreboard bench for fir_sym_stream.
// Three DUTs share stimulus: 32-bit out, 16-bit saturating, SHIFT=4.
module tb_fir_sym_stream;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 9;
    localparam int U    = 5;
    localparam int AW   = 3;
    localparam int LAT  = 7;
    localparam int SH   = 4;
    localparam longint DEF [U] = '{2, -5, 10, -20, 112};
    localparam longint IMP [TAPS] = '{2, -5, 10, -20, 112, -20, 10, -5, 2};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic coef_we = 1'b0;
    logic coef_swap = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic [AW-1:0] coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic ov_a, ov_b, ov_c;
    logic signed [31:0] do_a;
    logic signed [15:0] do_b;
    logic signed [31:0] do_c;

    fir_sym_stream #(.OUT_W(32), .SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_swap(coef_swap), .out_valid(ov_a), .data_out(do_a));

    fir_sym_stream #(.OUT_W(16), .SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_swap(coef_swap), .out_valid(ov_b), .data_out(do_b));

    fir_sym_stream #(.OUT_W(32), .SHIFT(SH)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_swap(coef_swap), .out_valid(ov_c), .data_out(do_c));

    always #5 clk = ~clk;

    typedef struct {
        int     edge_n;
        longint ya;
        longint yb;
        longint yc;
    } exp_t;

    typedef struct {
        int     edge_n;
        longint va;
        longint vb;
    } cap_t;

    exp_t   sb [$];
    cap_t   cap [$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    longint win [TAPS];
    longint pwin [TAPS];
    bit     pend;
    int     pend_edge;
    longint act [U];
    longint shd [U];
    longint last_a = 0;
    longint last_b = 0;
    exp_t   mon_e;
    cap_t   mon_c;

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd(input longint y, input int s);
        if (s == 0) return y;
        return (y + (longint'(1) << (s - 1))) >>> s;
    endfunction

    // Direct-form convolution with the mirrored impulse response.
    function automatic longint fir_out(input longint x [TAPS], input longint h [U]);
        longint y;
        y = 0;
        for (int j = 0; j < TAPS; j++)
            y += x[j] * h[(j < U) ? j : TAPS - 1 - j];
        return y;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        act  = DEF;
        shd  = DEF;
        for (int i = 0; i < TAPS; i++) win[i] = 0;
        pend = 1'b0;
        sb.delete();
    endtask

    task automatic step(input bit v, input longint d, input bit we,
                        input int addr, input longint cd, input bit sw);
        exp_t e;
        in_valid  = v;
        data_in   = DW'(d);
        coef_we   = we;
        coef_addr = AW'(addr);
        coef_data = CW'(cd);
        coef_swap = sw;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (we && addr < U) shd[addr] = cd;
            if (sw) act = shd;
            if (pend) begin
                longint y;
                y = fir_out(pwin, act);
                e.edge_n = pend_edge + LAT;
                e.ya = sat(y, 32);
                e.yb = sat(y, 16);
                e.yc = sat(rnd(y, SH), 32);
                sb.push_back(e);
                pend = 1'b0;
            end
            if (v) begin
                for (int i = TAPS - 1; i > 0; i--) win[i] = win[i - 1];
                win[0]    = d;
                pwin      = win;
                pend      = 1'b1;
                pend_edge = cyc;
            end
        end
        #1;
    endtask

    task automatic feed(input int n, input longint d);
        for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic cap_at(input string name, input int en, input longint exp);
        bit found;
        found = 1'b0;
        foreach (cap[i]) begin
            if (cap[i].edge_n == en) begin
                found = 1'b1;
                check(name, cap[i].va, exp);
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s: no output at edge %0d, expected %0d", name, en, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last_a = 0;
            last_b = 0;
        end else begin
            check("valid_b", ov_b, ov_a);
            check("valid_c", ov_c, ov_a);
            if (ov_a) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0d at edge %0d, expected none",
                             do_a, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", cyc, mon_e.edge_n);
                    check("out32", do_a, mon_e.ya);
                    check("out16", do_b, mon_e.yb);
                    check("out_shift", do_c, mon_e.yc);
                end
                mon_c.edge_n = cyc;
                mon_c.va = do_a;
                mon_c.vb = do_b;
                cap.push_back(mon_c);
                last_a = do_a;
                last_b = do_b;
            end else begin
                check("hold32", do_a, last_a);
                check("hold16", do_b, last_b);
            end
        end
    end

    initial begin
        int a0, s;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ov_a, 0);
        check("rst_data32", do_a, 0);
        check("rst_data16", do_b, 0);
        reset = 1'b0;
        idle(2);

        cap.delete();
        step(1'b1, 1, 1'b0, 0, 0, 1'b0);
        a0 = cyc;
        feed(12, 0);
        idle(10);
        check("imp_count", cap.size(), 13);
        check("imp_latency", cap[0].edge_n, a0 + LAT);
        for (int i = 0; i < TAPS; i++) check("imp_value", cap[i].va, IMP[i]);

        cap.delete();
        step(1'b1, 1, 1'b0, 0, 0, 1'b0);
        a0 = cyc;
        idle(1);
        for (int i = 0; i < 12; i++) begin
            feed(1, 0);
            idle(1);
        end
        idle(10);
        check("gap_count", cap.size(), 13);
        for (int i = 0; i < TAPS; i++) check("gap_value", cap[i].va, IMP[i]);
        for (int i = 0; i < 13; i++) check("gap_edge", cap[i].edge_n, a0 + LAT + 2 * i);

        cap.delete();
        feed(20, 100);
        idle(10);
        for (int i = 8; i < 20; i++) check("step_value", cap[i].va, 8600);

        cap.delete();
        feed(16, 32767);
        idle(10);
        check("sat_pos", cap[cap.size() - 1].vb, 32767);
        cap.delete();
        feed(16, -32768);
        idle(10);
        check("sat_neg", cap[cap.size() - 1].vb, -32768);

        cap.delete();
        feed(12, 100);
        for (int i = 0; i < U - 1; i++) step(1'b1, 100, 1'b1, i, 0, 1'b0);
        step(1'b1, 100, 1'b1, 4, 1, 1'b0);
        step(1'b1, 100, 1'b1, 5, 77, 1'b0);
        feed(10, 100);
        check("reload_pre", cap[cap.size() - 1].va, 8600);
        step(1'b1, 100, 1'b0, 0, 0, 1'b1);
        s = cyc;
        feed(12, 100);
        idle(10);
        cap_at("reload_old", s - 2 + LAT, 8600);
        cap_at("reload_new", s - 1 + LAT, 100);
        cap_at("reload_late", s + 5 + LAT, 100);

        feed(10, 100);
        #2;
        check("arst_pre_valid", ov_a, 1);
        reset = 1'b1;
        #1;
        check("arst_valid", ov_a, 0);
        check("arst_data", do_a, 0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #3;
        reset = 1'b0;
        cap.delete();
        step(1'b1, 100, 1'b0, 0, 0, 1'b0);
        a0 = cyc;
        feed(10, 100);
        idle(10);
        check("arst_first", cap[0].va, 200);
        check("arst_latency", cap[0].edge_n, a0 + LAT);
        check("arst_second", cap[1].va, -300);

        for (int i = 0; i < 400; i++) begin
            bit     v, we, sw;
            int     addr;
            longint d, cd;
            v    = ($urandom_range(0, 9) < 7);
            d    = longint'($urandom_range(0, 65535)) - 32768;
            we   = ($urandom_range(0, 9) == 0);
            addr = $urandom_range(0, 7);
            cd   = longint'($urandom_range(0, 255)) - 128;
            sw   = ($urandom_range(0, 19) == 0);
            step(v, d, we, addr, cd, sw);
        end
        idle(15);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
